// File: rtl/cpu_pkg.sv
// Shared processor definitions: instruction-type codes, unary R-type opcodes,
// and the hazard controller's memory-handshake state encoding.
package cpu_pkg;

  localparam logic [5:0] IT_R   = 6'b101010;
  localparam logic [5:0] IT_LD  = 6'b100000;
  localparam logic [5:0] IT_ST  = 6'b100001;
  localparam logic [5:0] IT_BEQ = 6'b100010;
  localparam logic [5:0] IT_BNE = 6'b100011;
  localparam logic [5:0] IT_NOP = 6'b111000;

  localparam int NUM_UNARY = 6;
  localparam logic [5:0] UNARY_OPS [NUM_UNARY] = '{
    6'b000100, 6'b000101, 6'b001101, 6'b010000, 6'b010001, 6'b010010
  };

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } mem_state_t;

  // Unary R-type ops read only reg1.
  function automatic logic is_unary(input logic [5:0] op);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_UNARY; i++) begin
      if (op == UNARY_OPS[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/src_use_dec.sv
// Decodes which ID-stage source registers an instruction actually reads.
// Shared with the forwarding unit so both agree on operand usage.
module src_use_dec
  import cpu_pkg::*;
(
  input  logic [5:0] instr_type,
  input  logic [5:0] opcode,
  output logic       use1,
  output logic       use2
);

  always_comb begin
    use1 = 1'b0;
    use2 = 1'b0;
    case (instr_type)
      IT_R: begin
        use1 = 1'b1;
        use2 = ~is_unary(opcode);
      end
      IT_ST, IT_BEQ, IT_BNE: use1 = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes, data-memory
// handshake sequencing with timeout, and a saturating stall-cycle counter.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_reg1,
  input  logic [4:0]       id_reg2,
  input  logic [5:0]       id_instr_type,
  input  logic [5:0]       id_opcode,
  input  logic [4:0]       ex_Wreg,
  input  logic             ex_Wreg_en,
  input  logic             ex_mem_en,
  input  logic             ex_Wmem_en,
  input  logic             ex_branch_taken,
  input  logic             mem_mem_en,
  input  logic             dmem_ack,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             idex_stall,
  output logic             exmem_stall,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             pc_redirect,
  output logic             dmem_req,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [7:0] TIMEOUT_VAL = 8'(MEM_TIMEOUT);

  logic       use1, use2;
  logic       lu;
  logic       mstall;
  logic       req_raw;
  mem_state_t state_reg, state_next;
  logic [7:0] wait_reg, wait_next;
  logic       mem_err_reg, mem_err_next;
  logic [CNT_W-1:0] cnt_reg;

  src_use_dec u_src_use_dec (
    .instr_type (id_instr_type),
    .opcode     (id_opcode),
    .use1       (use1),
    .use2       (use2)
  );

  // Register 0 is a real register here, so no zero-address exclusion.
  assign lu = ex_mem_en & ~ex_Wmem_en & ex_Wreg_en &
              ((use1 & (ex_Wreg == id_reg1)) | (use2 & (ex_Wreg == id_reg2)));

  always_comb begin
    state_next   = state_reg;
    wait_next    = wait_reg;
    mem_err_next = mem_err_reg;
    mstall       = 1'b0;
    req_raw      = 1'b0;
    case (state_reg)
      ST_RUN: begin
        req_raw = mem_mem_en;
        if (mem_mem_en & ~dmem_ack) begin
          mstall     = 1'b1;
          state_next = ST_MEM_WAIT;
          wait_next  = 8'd1;
        end
      end
      ST_MEM_WAIT: begin
        req_raw = 1'b1;
        mstall  = 1'b1;
        if (dmem_ack) begin
          state_next = ST_RUN;
        end else if (wait_reg == TIMEOUT_VAL) begin
          state_next   = ST_ERR;
          mem_err_next = 1'b1;
        end else begin
          wait_next = wait_reg + 8'd1;
        end
      end
      ST_ERR: begin
        mstall = 1'b1;
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  // Priority: memory stall, then taken branch, then load-use.
  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    idex_stall  = 1'b0;
    exmem_stall = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    pc_redirect = 1'b0;
    dmem_req    = 1'b0;
    if (!rst) begin
      dmem_req = req_raw;
      if (mstall) begin
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
        idex_stall  = 1'b1;
        exmem_stall = 1'b1;
      end else if (ex_branch_taken) begin
        pc_redirect = 1'b1;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
      end else if (lu) begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_flush = 1'b1;
      end
    end
  end

  assign mem_err   = mem_err_reg & ~rst;
  assign stall_cnt = rst ? '0 : cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_RUN;
      wait_reg    <= 8'd0;
      mem_err_reg <= 1'b0;
      cnt_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      wait_reg    <= wait_next;
      mem_err_reg <= mem_err_next;
      if (pc_stall && (cnt_reg != {CNT_W{1'b1}})) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_hazard_ctrl;

  localparam int TO = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    id_reg1, id_reg2, ex_Wreg;
  logic [5:0]    id_instr_type, id_opcode;
  logic          ex_Wreg_en, ex_mem_en, ex_Wmem_en, ex_branch_taken;
  logic          mem_mem_en, dmem_ack;
  logic          pc_stall, ifid_stall, idex_stall, exmem_stall;
  logic          ifid_flush, idex_flush, pc_redirect, dmem_req, mem_err;
  logic [CW-1:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_reg1         (id_reg1),
    .id_reg2         (id_reg2),
    .id_instr_type   (id_instr_type),
    .id_opcode       (id_opcode),
    .ex_Wreg         (ex_Wreg),
    .ex_Wreg_en      (ex_Wreg_en),
    .ex_mem_en       (ex_mem_en),
    .ex_Wmem_en      (ex_Wmem_en),
    .ex_branch_taken (ex_branch_taken),
    .mem_mem_en      (mem_mem_en),
    .dmem_ack        (dmem_ack),
    .pc_stall        (pc_stall),
    .ifid_stall      (ifid_stall),
    .idex_stall      (idex_stall),
    .exmem_stall     (exmem_stall),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .pc_redirect     (pc_redirect),
    .dmem_req        (dmem_req),
    .mem_err         (mem_err),
    .stall_cnt       (stall_cnt)
  );

  always #5 clk = ~clk;

  // Output vector order: pc,ifid,idex,exmem stall | ifid,idex flush | redirect | req | err
  function automatic logic [8:0] outs();
    return {pc_stall, ifid_stall, idex_stall, exmem_stall,
            ifid_flush, idex_flush, pc_redirect, dmem_req, mem_err};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  function automatic bit src_used(input logic [5:0] ty, input logic [5:0] op, input int idx);
    bit unary;
    unary = (op == 6'b000100) || (op == 6'b000101) || (op == 6'b001101) ||
            (op == 6'b010000) || (op == 6'b010001) || (op == 6'b010010);
    if (ty == 6'b101010) return (idx == 1) ? 1'b1 : !unary;
    if (idx == 1 && (ty == 6'b100001 || ty == 6'b100010 || ty == 6'b100011)) return 1'b1;
    return 1'b0;
  endfunction

  int m_wait = 0;   // 0: not waiting; k: k-th wait cycle
  bit m_err  = 0;
  int m_cnt  = 0;

  always @(negedge clk) begin : model
    logic [8:0] exp;
    int  exp_cnt;
    bit  lu, mst, req, ps, br;
    if (rst) begin
      exp = '0;
      exp_cnt = 0;
      m_wait = 0;
      m_err  = 0;
      m_cnt  = 0;
    end else begin
      br  = ex_branch_taken;
      lu  = ex_mem_en && !ex_Wmem_en && ex_Wreg_en &&
            ((src_used(id_instr_type, id_opcode, 1) && ex_Wreg == id_reg1) ||
             (src_used(id_instr_type, id_opcode, 2) && ex_Wreg == id_reg2));
      mst = m_err || (m_wait > 0) || (mem_mem_en && !dmem_ack);
      req = !m_err && ((m_wait > 0) || mem_mem_en);
      ps  = mst || (!br && lu);
      exp = {ps, ps, mst, mst, !mst && br, !mst && (br || lu), !mst && br, req, m_err};
      exp_cnt = m_cnt;
      if (ps) m_cnt = (m_cnt + 1 > (1 << CW) - 1) ? (1 << CW) - 1 : m_cnt + 1;
      if (!m_err) begin
        if (m_wait > 0) begin
          if (dmem_ack) m_wait = 0;
          else if (m_wait == TO) begin m_err = 1; m_wait = 0; end
          else m_wait++;
        end else if (mem_mem_en && !dmem_ack) begin
          m_wait = 1;
        end
      end
    end
    check("model_outs", 32'(outs()), 32'(exp));
    check("model_cnt", 32'(stall_cnt), 32'(exp_cnt));
  end

  // ---------------- stimulus ----------------
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle();
    id_reg1 = 5'd0; id_reg2 = 5'd0; ex_Wreg = 5'd0;
    id_instr_type = 6'b111000; id_opcode = 6'd0;
    ex_Wreg_en = 0; ex_mem_en = 0; ex_Wmem_en = 0; ex_branch_taken = 0;
    mem_mem_en = 0; dmem_ack = 0;
  endtask

  task automatic load_r5_add();
    ex_mem_en = 1; ex_Wmem_en = 0; ex_Wreg_en = 1; ex_Wreg = 5'd5;
    id_instr_type = 6'b101010; id_opcode = 6'b100000;
    id_reg1 = 5'd3; id_reg2 = 5'd5;
  endtask

  localparam logic [8:0] LU_PAT  = 9'b110001000;
  localparam logic [8:0] BR_PAT  = 9'b000011100;
  localparam logic [8:0] MW_PAT  = 9'b111100010;
  localparam logic [8:0] ERR_PAT = 9'b111100001;
  localparam logic [8:0] REQ_PAT = 9'b000000010;

  logic [5:0] types [7] = '{6'b101010, 6'b100000, 6'b100001, 6'b100010,
                            6'b100011, 6'b111000, 6'b000111};
  logic [5:0] ops [8] = '{6'b000100, 6'b000101, 6'b001101, 6'b010000,
                          6'b010001, 6'b010010, 6'b100000, 6'b100010};

  initial begin
    idle();
    rst = 1;
    mem_mem_en = 1;
    load_r5_add();
    mid();
    check("reset_outs", 32'(outs()), 32'd0);
    check("reset_cnt", 32'(stall_cnt), 32'd0);
    next(); idle(); rst = 0;

    // load-use: one bubble, then clear
    load_r5_add();
    mid(); check("lu_stall", 32'(outs()), 32'(LU_PAT));
    next(); idle();
    mid(); check("lu_release", 32'(outs()), 32'd0);
    check("lu_cnt", 32'(stall_cnt), 32'd1);

    next(); load_r5_add(); id_opcode = 6'b000100;
    mid(); check("unary_no_stall", 32'(outs()), 32'd0);

    next(); load_r5_add(); ex_Wreg = 5'd0; id_reg1 = 5'd0; id_reg2 = 5'd7;
    mid(); check("r0_lu", 32'(outs()), 32'(LU_PAT));

    next(); ex_branch_taken = 1;
    mid(); check("branch_over_lu", 32'(outs()), 32'(BR_PAT));

    next(); idle(); rst = 1;
    next(); rst = 0;

    // memory wait: ack on the third stalled cycle
    mem_mem_en = 1;
    for (int i = 0; i < 3; i++) begin
      dmem_ack = (i == 2);
      mid(); check("mem_wait", 32'(outs()), 32'(MW_PAT));
      next();
    end
    idle();
    mid(); check("mem_release", 32'(outs()), 32'd0);
    check("mem_cnt", 32'(stall_cnt), 32'd3);

    next(); mem_mem_en = 1; dmem_ack = 1;
    mid(); check("ack_first", 32'(outs()), 32'(REQ_PAT));

    // taken branch held during a two-cycle wait
    next(); dmem_ack = 0; ex_branch_taken = 1;
    mid(); check("br_wait0", 32'(outs()), 32'(MW_PAT));
    next(); dmem_ack = 1;
    mid(); check("br_wait_ack", 32'(outs()), 32'(MW_PAT));
    next(); mem_mem_en = 0; dmem_ack = 0;
    mid(); check("br_after_wait", 32'(outs()), 32'(BR_PAT));
    check("br_cnt", 32'(stall_cnt), 32'd5);

    // ack exactly on wait-cycle TO returns to RUN
    next(); idle(); mem_mem_en = 1;
    for (int i = 0; i < TO; i++) next();
    dmem_ack = 1;
    mid(); check("ack_at_limit", 32'(outs()), 32'(MW_PAT));
    next(); idle();
    mid(); check("after_limit_ack", 32'(outs()), 32'd0);

    // no ack: ERR on the (TO+1)-th edge
    next(); mem_mem_en = 1;
    for (int i = 0; i < TO; i++) next();
    mid(); check("wait_last", 32'(outs()), 32'(MW_PAT));
    next(); mem_mem_en = 0;
    mid(); check("timeout_err", 32'(outs()), 32'(ERR_PAT));
    next();
    mid(); check("err_sticky", 32'(outs()), 32'(ERR_PAT));

    next(); rst = 1;
    mid(); check("rst_in_err", 32'(outs()), 32'd0);
    next(); rst = 0;
    mid(); check("after_err_rst", 32'(outs()), 32'd0);
    check("after_err_cnt", 32'(stall_cnt), 32'd0);

    // saturation after 20 load-use stalls
    next(); load_r5_add();
    for (int i = 0; i < 20; i++) next();
    idle();
    mid(); check("cnt_saturate", 32'(stall_cnt), 32'd15);

    // reset in the middle of a wait
    next(); mem_mem_en = 1;
    next(); next(); rst = 1;
    mid(); check("rst_mid_wait", 32'(outs()), 32'd0);
    next(); rst = 0; mem_mem_en = 0;
    mid(); check("run_after_rst", 32'(outs()), 32'd0);
    check("cnt_after_rst", 32'(stall_cnt), 32'd0);
    next(); mem_mem_en = 1; dmem_ack = 1;
    mid(); check("run_req", 32'(outs()), 32'(REQ_PAT));

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      next();
      rst             = ($urandom_range(0, 59) == 0);
      id_instr_type   = types[$urandom_range(0, 6)];
      id_opcode       = ops[$urandom_range(0, 7)];
      id_reg1         = 5'($urandom_range(0, 3));
      id_reg2         = 5'($urandom_range(0, 3));
      ex_Wreg         = 5'($urandom_range(0, 3));
      ex_Wreg_en      = 1'($urandom_range(0, 1));
      ex_mem_en       = 1'($urandom_range(0, 1));
      ex_Wmem_en      = ($urandom_range(0, 3) == 0);
      ex_branch_taken = ($urandom_range(0, 4) == 0);
      mem_mem_en      = ($urandom_range(0, 2) == 0);
      dmem_ack        = ($urandom_range(0, 2) == 0);
    end
    next(); idle(); rst = 0;
    mid();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
